// File: rtl/vga_sync_if.sv
// Timing bundle produced by vga_sync: raster counters, syncs and strobes.
// The master side (vga_sync) drives every signal; renderers take the slave modport.
interface vga_sync_if;
  logic [15:0] Hcount;
  logic [15:0] Vcount;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic        pixel_tick;
  logic        frame_start;

  modport master (
    output Hcount, Vcount, hsync, vsync, video_on, pixel_tick, frame_start
  );

  modport slave (
    input Hcount, Vcount, hsync, vsync, video_on, pixel_tick, frame_start
  );
endinterface

// File: rtl/vga_sync.sv
// VGA raster timing generator: divides clk down to the pixel rate and produces
// counters, active-low syncs and a visible-area flag, all aligned to the counters.
module vga_sync #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       clk,
  input  logic       reset,
  vga_sync_if.master vga
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [15:0] H_LAST     = 16'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [15:0] V_LAST     = 16'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [15:0] H_VIS      = 16'(H_VISIBLE);
  localparam logic [15:0] V_VIS      = 16'(V_VISIBLE);
  localparam logic [15:0] HS_START   = 16'(H_VISIBLE + H_FP);
  localparam logic [15:0] HS_END     = 16'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [15:0] VS_START   = 16'(V_VISIBLE + V_FP);
  localparam logic [15:0] VS_END     = 16'(V_VISIBLE + V_FP + V_SYNC);

  logic [DIV_W-1:0] div_reg, div_next;
  logic [15:0]      h_reg, h_next;
  logic [15:0]      v_reg, v_next;
  logic             tick_reg;
  logic             hsync_reg, vsync_reg, video_on_reg, frame_start_reg;

  always_comb begin
    div_next = (div_reg == DIV_LAST) ? '0 : div_reg + 1'b1;
    h_next   = h_reg;
    v_next   = v_reg;
    // tick_reg is high exactly while the divider sits on its last count
    if (tick_reg) begin
      if (h_reg == H_LAST) begin
        h_next = '0;
        v_next = (v_reg == V_LAST) ? 16'd0 : v_reg + 16'd1;
      end else begin
        h_next = h_reg + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_reg         <= '0;
      tick_reg        <= 1'b0;
      h_reg           <= '0;
      v_reg           <= '0;
      hsync_reg       <= 1'b1;
      vsync_reg       <= 1'b1;
      video_on_reg    <= 1'b1;
      frame_start_reg <= 1'b0;
    end else begin
      div_reg         <= div_next;
      tick_reg        <= (div_next == DIV_LAST);
      h_reg           <= h_next;
      v_reg           <= v_next;
      // Decode from next-state counters so the flags line up with Hcount/Vcount
      hsync_reg       <= !((h_next >= HS_START) && (h_next < HS_END));
      vsync_reg       <= !((v_next >= VS_START) && (v_next < VS_END));
      video_on_reg    <= (h_next < H_VIS) && (v_next < V_VIS);
      frame_start_reg <= tick_reg && (h_reg == H_LAST) && (v_reg == V_LAST);
    end
  end

  assign vga.Hcount      = h_reg;
  assign vga.Vcount      = v_reg;
  assign vga.hsync       = hsync_reg;
  assign vga.vsync       = vsync_reg;
  assign vga.video_on    = video_on_reg;
  assign vga.pixel_tick  = tick_reg;
  assign vga.frame_start = frame_start_reg;

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: a default-timing instance and a shrunken-timing instance
// with random resets, both compared every clk against an arithmetic raster model.
module tb_vga_sync;

  localparam int NCYC = 35400;

  // Shrunken timing so whole frames fit in a short run
  localparam int B_DIV = 3;
  localparam int B_HV = 8, B_HF = 2, B_HS = 3, B_HB = 2;
  localparam int B_VV = 6, B_VF = 1, B_VS = 2, B_VB = 2;
  localparam int B_FRAME = (B_HV + B_HF + B_HS + B_HB) * (B_VV + B_VF + B_VS + B_VB) * B_DIV;

  typedef struct {
    int h;
    int v;
    bit hs;
    bit vs;
    bit vo;
    bit tick;
    bit fs;
  } exp_t;

  logic clk;
  logic rst_a, rst_b;
  int   total, bad;

  vga_sync_if ifa ();
  vga_sync_if ifb ();

  vga_sync dut_a (
    .clk   (clk),
    .reset (rst_a),
    .vga   (ifa)
  );

  vga_sync #(
    .CLK_DIV  (B_DIV),
    .H_VISIBLE(B_HV), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_VISIBLE(B_VV), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB)
  ) dut_b (
    .clk   (clk),
    .reset (rst_b),
    .vga   (ifb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // n = clk edges since the last edge that sampled reset high
  function automatic exp_t model(input longint n, input int div,
                                 input int hv, input int hf, input int hs, input int hb,
                                 input int vv, input int vf, input int vs, input int vb);
    exp_t   e;
    int     ht, vt;
    longint p;
    ht     = hv + hf + hs + hb;
    vt     = vv + vf + vs + vb;
    p      = n / div;
    e.h    = int'(p % ht);
    e.v    = int'((p / ht) % vt);
    e.hs   = !(e.h >= hv + hf && e.h < hv + hf + hs);
    e.vs   = !(e.v >= vv + vf && e.v < vv + vf + vs);
    e.vo   = (e.h < hv) && (e.v < vv);
    e.tick = (n % div) == longint'(div - 1);
    e.fs   = (n % div == 0) && (p > 0) && (p % (ht * vt) == 0);
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d at t=%0t", tag, got, want, $time);
    end
  endtask

  task automatic check_all(input string pfx, input logic [15:0] h, input logic [15:0] v,
                           input logic hs, input logic vs, input logic vo,
                           input logic tk, input logic fs, input exp_t e);
    chk({pfx, "_Hcount"},      32'(h),  e.h);
    chk({pfx, "_Vcount"},      32'(v),  e.v);
    chk({pfx, "_hsync"},       32'(hs), 32'(e.hs));
    chk({pfx, "_vsync"},       32'(vs), 32'(e.vs));
    chk({pfx, "_video_on"},    32'(vo), 32'(e.vo));
    chk({pfx, "_pixel_tick"},  32'(tk), 32'(e.tick));
    chk({pfx, "_frame_start"}, 32'(fs), 32'(e.fs));
  endtask

  initial begin
    longint na, nb;
    int     b_left, last_fs;
    bit     fs_valid;
    exp_t   ea, eb;
    total    = 0;
    bad      = 0;
    na       = 0;
    nb       = 0;
    b_left   = 0;
    last_fs  = 0;
    fs_valid = 1'b0;
    rst_a    = 1'b1;
    rst_b    = 1'b1;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      // Default instance: 3-clk reset at start, then one mid-tick reset late in the run
      rst_a = (cyc < 3) || (cyc == 35300);
      if (cyc < 3) begin
        rst_b = 1'b1;
      end else if (b_left > 0) begin
        rst_b = 1'b1;
        b_left--;
      end else if ($urandom_range(2999, 0) == 0) begin
        rst_b  = 1'b1;
        b_left = int'($urandom_range(2, 0));
        $display("reset b asserted at cycle %0d (H=%0d V=%0d)", cyc, ifb.Hcount, ifb.Vcount);
      end else begin
        rst_b = 1'b0;
      end

      @(posedge clk);
      na = rst_a ? 0 : na + 1;
      nb = rst_b ? 0 : nb + 1;
      #1;

      ea = model(na, 4, 640, 16, 96, 48, 480, 10, 2, 33);
      eb = model(nb, B_DIV, B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB);
      check_all("a", ifa.Hcount, ifa.Vcount, ifa.hsync, ifa.vsync, ifa.video_on,
                ifa.pixel_tick, ifa.frame_start, ea);
      check_all("b", ifb.Hcount, ifb.Vcount, ifb.hsync, ifb.vsync, ifb.video_on,
                ifb.pixel_tick, ifb.frame_start, eb);

      if (!rst_a && ifa.pixel_tick === 1'b0 && ifa.Hcount == 16'd0 && (na % 4) == 0 && na > 0)
        $display("line a: Vcount=%0d at cycle %0d", ifa.Vcount, cyc);

      // Independent frame-period measurement on the shrunken instance
      if (rst_b) begin
        fs_valid = 1'b0;
      end else if (ifb.frame_start === 1'b1) begin
        if (fs_valid)
          chk("b_frame_period", 32'(cyc - last_fs), 32'(B_FRAME));
        $display("frame b started at cycle %0d", cyc);
        last_fs  = cyc;
        fs_valid = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
